hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Pipeline hazard controller for the EX-side consumer of the ID/EX pipeline register in the 5-stage 64-bit CPU.
- Compares the instruction now in EX (ID/EX outputs) against source registers decoded in ID.
- Drives PC/IF-ID write enables, the IF/ID flush, and the ID/EX bubble (control-zeroing) select.
- Small FSM sequences multi-cycle load-use stalls and taken-branch flushes.

Parameters:
LOAD_STALL_CYCLES, 1, cycles PC and IF/ID are frozen on a load-use hazard (1..7)
FLUSH_CYCLES, 2, cycles IF/ID flush and ID/EX bubble are asserted after a taken branch (1..7)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous reset, active-low (0 = reset)
MemRead_EX  input  1  instruction in EX is a load
RegWrite_EX  input  1  instruction in EX writes the register file
Rd_EX  input  5  destination register of the instruction in EX
Rn_ID  input  5  first source register in ID
Rm_ID  input  5  second source register in ID
use_Rn_ID  input  1  the ID instruction reads Rn
use_Rm_ID  input  1  the ID instruction reads Rm
branch_taken_EX  input  1  branch resolved taken in EX (B, BL, BR, taken CBZ/B.cond)
pc_write_en  output  1  PC register load enable
if_id_write_en  output  1  IF/ID register load enable
if_id_flush  output  1  IF/ID loads a NOP
id_ex_bubble  output  1  ID/EX control inputs forced to 0
hazard_state  output  2  current FSM state (RUN=0, LSTALL=1, FLUSH=2)

Behaviour:
- States: RUN, LSTALL, FLUSH. The state register and a 3-bit down-counter cnt are the only sequential state (plus the optional counters).
- reset=0 (async): state=RUN, cnt=0. Outputs during reset: pc_write_en=1, if_id_write_en=1, if_id_flush=0, id_ex_bubble=0, hazard_state=0.
- luh (load-use hazard) = MemRead_EX & RegWrite_EX & (Rd_EX!=31) & ((use_Rn_ID & Rn_ID==Rd_EX) | (use_Rm_ID & Rm_ID==Rd_EX)). X31 never causes a hazard.
- Outputs are combinational from state and current inputs, with zero-cycle latency, so the stall or flush takes effect at the same edge the hazard is seen.
- Priority in every state: branch_taken_EX > luh > current-state behaviour.
- branch_taken_EX=1 in any state:
  - Outputs this cycle: if_id_flush=1, id_ex_bubble=1, pc_write_en=1, if_id_write_en=1.
  - If FLUSH_CYCLES>1: next state=FLUSH, cnt=FLUSH_CYCLES-2. Otherwise next state=RUN.
  - A taken branch arriving during FLUSH restarts the count.
- RUN with luh=1:
  - Outputs: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, if_id_flush=0.
  - If LOAD_STALL_CYCLES>1: next state=LSTALL, cnt=LOAD_STALL_CYCLES-2. Otherwise stay in RUN.
- RUN with no event: all enables 1, flush/bubble 0.
- LSTALL: pc_write_en=0, if_id_write_en=0, id_ex_bubble=1. If cnt==0, next state=RUN; else cnt-=1.
- FLUSH: if_id_flush=1, id_ex_bubble=1, pc_write_en=1, if_id_write_en=1. If cnt==0, next state=RUN; else cnt-=1.
- Back-to-back load-use hazards (a new luh on the cycle the FSM returns to RUN) re-stall immediately without a gap cycle.
- Reset asserted mid-LSTALL or mid-FLUSH: returns to RUN asynchronously and any remaining count is discarded.
- Parameter values outside 1..7 are a compile-time error (elaboration assertion).

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs stall_cycles[31:0] and flush_cycles[31:0].
  - stall_cycles increments on every cycle with pc_write_en=0.
  - flush_cycles increments on every cycle with if_id_flush=1.
  - Both saturate at 32'hFFFFFFFF, clear on reset, and are read-only.
- Undefined: the ports and counters are absent. Core behaviour is identical either way.

Decomposition:
- Shared package cpu_pipe_pkg:
  - enum hazard_state_t {RUN, LSTALL, FLUSH} (2-bit)
  - localparam XZR=5'd31
  - localparam REG_ADDR_W=5
- Sub-module hazard_cmp: purely combinational luh compare, reused later by the EX/MEM forwarding unit.
- The FSM and counter stay in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles with branch_taken_EX=1 -> pc_write_en=1, if_id_write_en=1, flush=0, bubble=0, hazard_state=0. Release -> first edge flushes.
- Load-use: MemRead_EX=1, RegWrite_EX=1, Rd_EX=3, Rn_ID=3, use_Rn_ID=1 for one cycle -> pc_write_en=0, bubble=1 that cycle. With Rd_EX=31 instead -> no stall.
- Multi-stall: LOAD_STALL_CYCLES=3 with luh pulsed once -> exactly 3 cycles pc_write_en=0, hazard_state 0→1→1→0.
- Branch: FLUSH_CYCLES=2 with branch_taken_EX pulse -> if_id_flush=1 for 2 cycles and pc_write_en held 1. A second pulse on the flush cycle -> 2 more cycles of flush.
- Priority: luh and branch_taken_EX both asserted in RUN -> flush behaviour and no PC freeze. Reset asserted mid-LSTALL -> immediate RUN outputs.
- HAZARD_PERF_EN: 4 stall cycles plus 2 flush cycles -> stall_cycles=4, flush_cycles=2. Preload near saturation -> counter holds at FFFFFFFF.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types and constants for the 5-stage 64-bit CPU.
package cpu_pipe_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned HAZ_CNT_W  = 3;
    localparam int unsigned PERF_W     = 32;

    localparam logic [REG_ADDR_W-1:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard compare: an in-flight load whose destination matches a source
// register read in ID. XZR never creates a dependency.
module hazard_cmp
    import cpu_pipe_pkg::*;
(
    input  logic                  i_mem_read,
    input  logic                  i_reg_write,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic [REG_ADDR_W-1:0] i_rn,
    input  logic                  i_use_rn,
    input  logic [REG_ADDR_W-1:0] i_rm,
    input  logic                  i_use_rm,
    output logic                  o_luh_c
);

    logic w_rn_hit;
    logic w_rm_hit;

    // Per-operand match and final hazard decision
    always_comb begin
        w_rn_hit = i_use_rn && (i_rn == i_rd);
        w_rm_hit = i_use_rm && (i_rm == i_rd);
        o_luh_c  = i_mem_read && i_reg_write && (i_rd != XZR) && (w_rn_hit || w_rm_hit);
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the ID/EX consumer: freezes PC and IF/ID on load-use
// hazards and flushes IF/ID + bubbles ID/EX after taken branches.
// Optional feature macro: HAZARD_PERF_EN (adds stall_cycles / flush_cycles counters).
module hazard_stall_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead_EX,
    input  logic                  RegWrite_EX,
    input  logic [REG_ADDR_W-1:0] Rd_EX,
    input  logic [REG_ADDR_W-1:0] Rn_ID,
    input  logic [REG_ADDR_W-1:0] Rm_ID,
    input  logic                  use_Rn_ID,
    input  logic                  use_Rm_ID,
    input  logic                  branch_taken_EX,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic [1:0]            hazard_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]     stall_cycles,
    output logic [PERF_W-1:0]     flush_cycles
`endif
);

    // Parameter range checks at elaboration
    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 7) begin : g_bad_lsc
        $error("hazard_stall_ctrl: LOAD_STALL_CYCLES must be 1..7");
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_fc
        $error("hazard_stall_ctrl: FLUSH_CYCLES must be 1..7");
    end

    hazard_state_t          r_state;
    hazard_state_t          w_next_state;
    logic [HAZ_CNT_W-1:0]   r_cnt;
    logic [HAZ_CNT_W-1:0]   w_next_cnt;
    logic                   w_luh;

    hazard_cmp u_cmp (
        .i_mem_read  (MemRead_EX),
        .i_reg_write (RegWrite_EX),
        .i_rd        (Rd_EX),
        .i_rn        (Rn_ID),
        .i_use_rn    (use_Rn_ID),
        .i_rm        (Rm_ID),
        .i_use_rm    (use_Rm_ID),
        .o_luh_c     (w_luh)
    );

    // State and countdown register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next state and zero-latency control outputs; branch > load-use > state
    always_comb begin
        w_next_state   = r_state;
        w_next_cnt     = r_cnt;
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;

        if (!reset) begin
            w_next_state = RUN;
            w_next_cnt   = '0;
        end else if (branch_taken_EX) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_next_state = FLUSH;
                w_next_cnt   = HAZ_CNT_W'(FLUSH_CYCLES - 2);
            end else begin
                w_next_state = RUN;
                w_next_cnt   = '0;
            end
        end else if (w_luh) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                w_next_state = LSTALL;
                w_next_cnt   = HAZ_CNT_W'(LOAD_STALL_CYCLES - 2);
            end else begin
                w_next_state = RUN;
                w_next_cnt   = '0;
            end
        end else begin
            case (r_state)
                RUN: begin
                    w_next_state = RUN;
                end
                LSTALL: begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_bubble   = 1'b1;
                    if (r_cnt == '0) w_next_state = RUN;
                    else             w_next_cnt   = r_cnt - HAZ_CNT_W'(1);
                end
                FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (r_cnt == '0) w_next_state = RUN;
                    else             w_next_cnt   = r_cnt - HAZ_CNT_W'(1);
                end
                default: begin
                    w_next_state = RUN;
                    w_next_cnt   = '0;
                end
            endcase
        end
    end

    assign hazard_state = r_state;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] r_stall_cycles;
    logic [PERF_W-1:0] r_flush_cycles;

    // Saturating stall and flush cycle counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            if (!pc_write_en && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + PERF_W'(1);
            if (if_id_flush && (r_flush_cycles != '1))
                r_flush_cycles <= r_flush_cycles + PERF_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_cycles = r_flush_cycles;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with a queue scoreboard fed by a
// behavioural reference of the stall/flush sequencing.
module tb_hazard_stall_ctrl;

    localparam int unsigned LSC = 3;
    localparam int unsigned FC  = 2;

    logic       clk;
    logic       reset;
    logic       MemRead_EX;
    logic       RegWrite_EX;
    logic [4:0] Rd_EX;
    logic [4:0] Rn_ID;
    logic [4:0] Rm_ID;
    logic       use_Rn_ID;
    logic       use_Rm_ID;
    logic       branch_taken_EX;
    logic       pc_write_en;
    logic       if_id_write_en;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic [1:0] hazard_state;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_cycles;
`endif

    hazard_stall_ctrl #(
        .LOAD_STALL_CYCLES (LSC),
        .FLUSH_CYCLES      (FC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .MemRead_EX      (MemRead_EX),
        .RegWrite_EX     (RegWrite_EX),
        .Rd_EX           (Rd_EX),
        .Rn_ID           (Rn_ID),
        .Rm_ID           (Rm_ID),
        .use_Rn_ID       (use_Rn_ID),
        .use_Rm_ID       (use_Rm_ID),
        .branch_taken_EX (branch_taken_EX),
        .pc_write_en     (pc_write_en),
        .if_id_write_en  (if_id_write_en),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .hazard_state    (hazard_state)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_cycles    (flush_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: {pc_we, ifid_we, flush, bubble, state[1:0]}
    logic [5:0] exp_q[$];
    string      tag_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         m_state  = 0;
    int         m_cnt    = 0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;
    logic [5:0] last_obs;

    task automatic compare(input logic [5:0] obs, input logic [5:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b (pc,ifid,flush,bubble,state)", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, predict outputs, then check them before the next edge
    task automatic step(input logic rst, input logic br, input logic mr, input logic rw,
                        input logic [4:0] rd, input logic [4:0] rn, input logic urn,
                        input logic [4:0] rm, input logic urm, input string tag);
        logic [5:0] e;
        logic [5:0] obs;
        logic       luh;
        int         ns;
        int         nc;
        @(negedge clk);
        reset = rst; branch_taken_EX = br; MemRead_EX = mr; RegWrite_EX = rw;
        Rd_EX = rd; Rn_ID = rn; use_Rn_ID = urn; Rm_ID = rm; use_Rm_ID = urm;

        luh = mr && rw && (rd != 5'd31) && ((urn && rn == rd) || (urm && rm == rd));
        ns = m_state; nc = m_cnt;
        if (!rst) begin
            e = 6'b110000; ns = 0; nc = 0;
        end else if (br) begin
            e = {4'b1111, 2'(m_state)};
            ns = (FC > 1) ? 2 : 0; nc = (FC > 1) ? int'(FC) - 2 : 0;
        end else if (luh) begin
            e = {4'b0001, 2'(m_state)};
            ns = (LSC > 1) ? 1 : 0; nc = (LSC > 1) ? int'(LSC) - 2 : 0;
        end else if (m_state == 1) begin
            e = 6'b000101;
            if (m_cnt == 0) ns = 0; else nc = m_cnt - 1;
        end else if (m_state == 2) begin
            e = 6'b111110;
            if (m_cnt == 0) ns = 0; else nc = m_cnt - 1;
        end else begin
            e = 6'b110000;
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);

        #1;
        obs = {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, hazard_state};
        last_obs = obs;
        compare(obs, exp_q.pop_front(), tag_q.pop_front());

        if (!rst) begin
            m_stall = '0; m_flush = '0;
        end else begin
            if (!e[5] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (e[3] && m_flush != 32'hFFFF_FFFF)  m_flush = m_flush + 32'd1;
        end
        m_state = ns; m_cnt = nc;
    endtask

    task automatic idle(input string tag);
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, tag);
    endtask

    task automatic load_use(input string tag);
        step(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, tag);
    endtask

    task automatic branch(input string tag);
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, tag);
    endtask

    initial begin
        int stalls;
        reset = 1'b0; branch_taken_EX = 1'b1; MemRead_EX = 1'b0; RegWrite_EX = 1'b0;
        Rd_EX = '0; Rn_ID = '0; Rm_ID = '0; use_Rn_ID = 1'b0; use_Rm_ID = 1'b0;

        // Reset held with a taken branch present
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, "reset_hold");
        branch("reset_release_flush");
        idle("reset_release_flush2");
        idle("run_idle");

        // Single load-use hazard with LSC=3: 0 -> 1 -> 1 -> 0
        stalls = 0;
        load_use("luh_rn");        if (!last_obs[5]) stalls++;
        idle("lstall_1");          if (!last_obs[5]) stalls++;
        idle("lstall_2");          if (!last_obs[5]) stalls++;
        idle("lstall_done");       if (!last_obs[5]) stalls++;
        compare(6'(stalls), 6'd3, "stall_cycle_count");

        // Non-hazard patterns
        step(1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 5'd31, 1'b1, 5'd31, 1'b1, "xzr_no_stall");
        step(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 5'd7, 1'b0, 5'd2, 1'b1, "unused_rn_no_stall");
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, "not_load_no_stall");
        step(1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, "no_regwrite_no_stall");

        // Hazard via Rm, then back-to-back re-stall on the return-to-RUN cycle
        step(1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 5'd1, 1'b1, 5'd12, 1'b1, "luh_rm");
        idle("lstall_rm_1");
        idle("lstall_rm_2");
        load_use("luh_back_to_back");
        idle("b2b_lstall_1");
        idle("b2b_lstall_2");
        idle("b2b_run");

        // Taken branch with a second pulse during flush restarts the count
        branch("branch_pulse");
        branch("branch_restart");
        idle("flush_tail");
        idle("flush_done");

        // Branch beats load-use in RUN
        step(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, "prio_branch_over_luh");
        idle("prio_flush");
        idle("prio_run");

        // Branch during a load stall
        load_use("luh_then_branch");
        branch("branch_in_lstall");
        idle("flush_after_lstall");
        idle("run_after_lstall_branch");

        // Async reset mid-LSTALL and mid-FLUSH
        load_use("luh_pre_reset");
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, "reset_mid_lstall");
        idle("run_after_lstall_reset");
        branch("branch_pre_reset");
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, "reset_mid_flush");
        idle("run_after_flush_reset");

`ifdef HAZARD_PERF_EN
        // Perf counters after reset: 3 stalls + 1 extra via back-to-back, 2 flush cycles
        load_use("perf_luh");
        idle("perf_lstall_1");
        idle("perf_lstall_2");
        load_use("perf_luh_single");
        branch("perf_branch");
        idle("perf_flush");
        idle("perf_settle");
        @(negedge clk); #1;
        compare(6'(stall_cycles == m_stall), 6'd1, "perf_stall_cycles");
        compare(6'(stall_cycles == 32'd4), 6'd1, "perf_stall_is_4");
        compare(6'(flush_cycles == 32'd2), 6'd1, "perf_flush_is_2");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
